// File: rtl/accumulator_pkg.sv
// rtl/accumulator_pkg.sv - shared types and sign-extension helper for the ping/pong accumulator
package accumulator_pkg;

    localparam int SEXT_W = 64;

    typedef enum logic [1:0] {
        BW2    = 2'd0,
        BW4    = 2'd1,
        BW8    = 2'd2,
        BWFULL = 2'd3
    } bitwidth_e;

    typedef enum logic [1:0] {
        CTRL_ACCUM,
        CTRL_FLUSH,
        CTRL_WAIT_DRAIN,
        CTRL_SWAP
    } ctrl_state_e;

    typedef enum logic {
        DRAIN_IDLE,
        DRAIN_STREAM
    } drain_state_e;

    // Sign-extend the low w bits of raw, w chosen by the beat's bitwidth code.
    function automatic logic signed [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] raw,
                                                      input bitwidth_e bw,
                                                      input int full_w);
        int w;
        logic signed [SEXT_W-1:0] t;
        case (bw)
            BW2:     w = 2;
            BW4:     w = 4;
            BW8:     w = 8;
            default: w = full_w;
        endcase
        t = $signed(raw << (SEXT_W - w));
        return t >>> (SEXT_W - w);
    endfunction

endpackage

// File: rtl/accumulator_entry_array.sv
// rtl/accumulator_entry_array.sv - one accumulator bank: entry storage plus per-entry zero flags
module accumulator_entry_array #(
    parameter int NUM_ENTRIES = 64,
    parameter int NUM_PORTS   = 2,
    parameter int ACC_WIDTH   = 16,
    localparam int AW = $clog2(NUM_ENTRIES)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS*AW-1:0]        rd_addr,
    output logic [NUM_PORTS*ACC_WIDTH-1:0] rd_data,
    input  logic [NUM_PORTS-1:0]           wr_en,
    input  logic [NUM_PORTS*AW-1:0]        wr_addr,
    input  logic [NUM_PORTS*ACC_WIDTH-1:0] wr_data,
    input  logic                           clr_en,
    input  logic [AW-1:0]                  clr_addr
);
    logic [ACC_WIDTH-1:0]   mem [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] zero_flag;

    // Write ports always target distinct entries; the top merges same-address lanes.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (wr_en[p]) begin
                mem[wr_addr[p*AW +: AW]] <= wr_data[p*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_flag <= '1;
        end else begin
            if (clr_en) begin
                zero_flag[clr_addr] <= 1'b1;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (wr_en[p]) begin
                    zero_flag[wr_addr[p*AW +: AW]] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_data[p*ACC_WIDTH +: ACC_WIDTH] = zero_flag[rd_addr[p*AW +: AW]] ? '0
                                              : mem[rd_addr[p*AW +: AW]];
        end
    end

endmodule

// File: rtl/pingpong_accumulator_bank.sv
// rtl/pingpong_accumulator_bank.sv - double-buffered partial-sum accumulator with streaming drain
module pingpong_accumulator_bank
    import accumulator_pkg::*;
#(
    parameter int NUM_ENTRIES = 64,
    parameter int NUM_LANES   = 2,
    parameter int IN_WIDTH    = 8,
    parameter int ACC_WIDTH   = 16,
    localparam int AW = $clog2(NUM_ENTRIES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    bitwidth,
    input  logic [NUM_LANES-1:0]          acc_valid,
    output logic                          acc_ready,
    input  logic [NUM_LANES*AW-1:0]       acc_addr,
    input  logic [NUM_LANES*IN_WIDTH-1:0] acc_data,
    input  logic                          swap_req,
    output logic                          swap_ack,
    output logic                          active_bank,
    output logic                          drain_valid,
    input  logic                          drain_ready,
    output logic [ACC_WIDTH-1:0]          drain_data,
    output logic [AW-1:0]                 drain_addr,
    output logic                          drain_last,
    output logic                          overflow
);
    localparam int MW  = ACC_WIDTH + $clog2(NUM_LANES) + 1;
    localparam int SW  = MW + 1;
    localparam int AVW = NUM_LANES * AW;
    localparam logic signed [SW-1:0] SAT_MAX =
        $signed({{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}});
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    ctrl_state_e  ctrl_state, ctrl_next;
    drain_state_e drain_state, drain_next;
    logic         rst_done, drain_start, drain_fire, acc_fire;

    logic signed [MW-1:0]            merge_val [NUM_LANES];
    logic [NUM_LANES-1:0]            merge_vld;
    logic [NUM_LANES-1:0]            s1_vld;
    logic [AVW-1:0]                  s1_addr;
    logic signed [MW-1:0]            s1_val [NUM_LANES];
    logic [NUM_LANES*ACC_WIDTH-1:0]  bank_rd [2];
    logic [NUM_LANES*ACC_WIDTH-1:0]  acc_rd, wr_data;
    logic [NUM_LANES-1:0]            clamp;
    logic signed [SW-1:0]            sum;
    logic [ACC_WIDTH-1:0]            drain_rd;

    assign acc_fire = acc_ready && (|acc_valid);

    // S1: sign-extend and fold later lanes into the first lane sharing their address.
    always_comb begin
        merge_vld = acc_valid;
        for (int l = 0; l < NUM_LANES; l++) begin
            merge_val[l] = MW'(sext(SEXT_W'(acc_data[l*IN_WIDTH +: IN_WIDTH]),
                                    bitwidth_e'(bitwidth), IN_WIDTH));
        end
        for (int l = 1; l < NUM_LANES; l++) begin
            for (int k = 0; k < l; k++) begin
                if (merge_vld[l] && merge_vld[k] &&
                    acc_addr[l*AW +: AW] == acc_addr[k*AW +: AW]) begin
                    merge_val[k] = merge_val[k] + merge_val[l];
                    merge_vld[l] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld  <= '0;
            s1_addr <= '0;
            for (int l = 0; l < NUM_LANES; l++) s1_val[l] <= '0;
        end else begin
            s1_vld <= acc_fire ? merge_vld : '0;
            if (acc_fire) begin
                s1_addr <= acc_addr;
                s1_val  <= merge_val;
            end
        end
    end

    // S2 reads, adds and writes back in one cycle, so the next beat always sees the new value.
    always_comb begin
        acc_rd  = active_bank ? bank_rd[1] : bank_rd[0];
        wr_data = '0;
        clamp   = '0;
        sum     = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            sum = SW'($signed(acc_rd[l*ACC_WIDTH +: ACC_WIDTH])) + SW'(s1_val[l]);
            if (sum > SAT_MAX) begin
                wr_data[l*ACC_WIDTH +: ACC_WIDTH] = SAT_MAX[ACC_WIDTH-1:0];
                clamp[l] = 1'b1;
            end else if (sum < SAT_MIN) begin
                wr_data[l*ACC_WIDTH +: ACC_WIDTH] = SAT_MIN[ACC_WIDTH-1:0];
                clamp[l] = 1'b1;
            end else begin
                wr_data[l*ACC_WIDTH +: ACC_WIDTH] = sum[ACC_WIDTH-1:0];
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic is_active;
        assign is_active = (active_bank == 1'(b));

        accumulator_entry_array #(
            .NUM_ENTRIES (NUM_ENTRIES),
            .NUM_PORTS   (NUM_LANES),
            .ACC_WIDTH   (ACC_WIDTH)
        ) u_array (
            .clk      (clk),
            .reset    (reset),
            .rd_addr  (is_active ? s1_addr : AVW'(drain_addr)),
            .rd_data  (bank_rd[b]),
            .wr_en    (is_active ? s1_vld : '0),
            .wr_addr  (s1_addr),
            .wr_data  (wr_data),
            .clr_en   (!is_active && drain_fire),
            .clr_addr (drain_addr)
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_state  <= CTRL_ACCUM;
            rst_done    <= 1'b0;
            active_bank <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            ctrl_state <= ctrl_next;
            rst_done   <= 1'b1;
            overflow   <= overflow | (|(s1_vld & clamp));
            if (ctrl_state == CTRL_SWAP) active_bank <= ~active_bank;
        end
    end

    always_comb begin
        ctrl_next   = ctrl_state;
        acc_ready   = 1'b0;
        swap_ack    = 1'b0;
        drain_start = 1'b0;
        case (ctrl_state)
            CTRL_ACCUM: begin
                acc_ready = rst_done && !swap_req;
                if (swap_req) ctrl_next = CTRL_FLUSH;
            end
            CTRL_FLUSH:      if (s1_vld == '0) ctrl_next = CTRL_WAIT_DRAIN;
            CTRL_WAIT_DRAIN: if (drain_state == DRAIN_IDLE) ctrl_next = CTRL_SWAP;
            default: begin
                swap_ack    = 1'b1;
                drain_start = 1'b1;
                ctrl_next   = CTRL_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_state <= DRAIN_IDLE;
            drain_addr  <= '0;
        end else begin
            drain_state <= drain_next;
            if (drain_fire) drain_addr <= drain_addr + 1'b1;
        end
    end

    always_comb begin
        drain_next  = drain_state;
        drain_valid = 1'b0;
        case (drain_state)
            DRAIN_IDLE: if (drain_start) drain_next = DRAIN_STREAM;
            default: begin
                drain_valid = 1'b1;
                if (drain_ready && drain_addr == AW'(NUM_ENTRIES-1)) drain_next = DRAIN_IDLE;
            end
        endcase
    end

    assign drain_fire = drain_valid && drain_ready;
    assign drain_rd   = active_bank ? bank_rd[0][ACC_WIDTH-1:0] : bank_rd[1][ACC_WIDTH-1:0];
    assign drain_data = drain_valid ? drain_rd : '0;
    assign drain_last = drain_valid && (drain_addr == AW'(NUM_ENTRIES-1));

endmodule

// File: tb/tb_pingpong_accumulator_bank.sv
// tb/tb_pingpong_accumulator_bank.sv - randomized bench against a tile-level reference model
`timescale 1ns/1ps
module tb_pingpong_accumulator_bank;
    localparam int NE = 64;
    localparam int NL = 2;
    localparam int IW = 8;
    localparam int AW = 6;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [1:0]     bitwidth = 2'd0;
    logic [NL-1:0]  acc_valid = '0;
    logic           acc_ready;
    logic [NL*AW-1:0] acc_addr = '0;
    logic [NL*IW-1:0] acc_data = '0;
    logic           swap_req = 1'b0;
    logic           swap_ack, active_bank, drain_valid, drain_last, overflow;
    logic           drain_ready = 1'b0;
    logic [15:0]    drain_data;
    logic [AW-1:0]  drain_addr;

    always #5 clk = ~clk;

    pingpong_accumulator_bank dut (
        .clk(clk), .reset(reset), .bitwidth(bitwidth), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .acc_addr(acc_addr), .acc_data(acc_data),
        .swap_req(swap_req), .swap_ack(swap_ack), .active_bank(active_bank),
        .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_data(drain_data),
        .drain_addr(drain_addr), .drain_last(drain_last), .overflow(overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: accumulating tile, tile being streamed, role bit, sticky overflow.
    int          m_acc [NE];
    int          m_drn [NE];
    int          m_idx = 0;
    bit          m_draining = 0;
    bit          m_active = 0;
    bit          m_ovf = 0;
    int          drained_tiles = 0;
    int          ack_count = 0;
    logic [15:0] got_tile [NE];
    bit          prev_stall = 0;
    logic [15:0] prev_data;
    logic [AW-1:0] prev_addr;
    int          dr_mode = 1;

    function automatic int lane_val(input logic [7:0] d, input logic [1:0] bw);
        int w;
        int v;
        w = (bw == 2'd0) ? 2 : (bw == 2'd1) ? 4 : 8;
        v = int'(d) & ((1 << w) - 1);
        if (v >= (1 << (w - 1))) v = v - (1 << w);
        return v;
    endfunction

    task automatic model_beat();
        bit used [NL];
        int a, s, t;
        for (int l = 0; l < NL; l++) used[l] = 0;
        for (int l = 0; l < NL; l++) begin
            if (acc_valid[l] && !used[l]) begin
                a = int'(acc_addr[l*AW +: AW]);
                s = lane_val(acc_data[l*IW +: IW], bitwidth);
                for (int k = l + 1; k < NL; k++) begin
                    if (acc_valid[k] && !used[k] && int'(acc_addr[k*AW +: AW]) == a) begin
                        s = s + lane_val(acc_data[k*IW +: IW], bitwidth);
                        used[k] = 1;
                    end
                end
                t = m_acc[a] + s;
                if (t > 32767) begin t = 32767; m_ovf = 1; end
                else if (t < -32768) begin t = -32768; m_ovf = 1; end
                m_acc[a] = t;
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_acc_ready", acc_ready, 0);
            chk("rst_swap_ack", swap_ack, 0);
            chk("rst_active_bank", active_bank, 0);
            chk("rst_drain_valid", drain_valid, 0);
            chk("rst_drain_data", drain_data, 0);
            chk("rst_drain_addr", drain_addr, 0);
            chk("rst_drain_last", drain_last, 0);
            chk("rst_overflow", overflow, 0);
            for (int i = 0; i < NE; i++) m_acc[i] = 0;
            m_draining = 0; m_idx = 0; m_active = 0; m_ovf = 0; prev_stall = 0;
        end else begin
            chk("active_bank", active_bank, m_active);
            chk("drain_valid", drain_valid, m_draining);
            if (prev_stall) begin
                chk("stall_data", drain_data, prev_data);
                chk("stall_addr", drain_addr, prev_addr);
            end
            if (drain_valid && drain_ready && m_draining) begin
                chk("drain_addr", drain_addr, m_idx);
                chk("drain_data", drain_data, m_drn[m_idx] & 32'hFFFF);
                chk("drain_last", drain_last, m_idx == NE - 1);
                got_tile[m_idx] = drain_data;
                m_idx++;
                if (m_idx == NE) begin
                    m_draining = 0;
                    drained_tiles++;
                end
            end
            prev_stall = drain_valid && !drain_ready;
            prev_data  = drain_data;
            prev_addr  = drain_addr;
            if (acc_ready && (|acc_valid)) model_beat();
            if (swap_ack) begin
                chk("swap_while_draining", m_draining, 0);
                chk("overflow", overflow, m_ovf);
                m_drn = m_acc;
                for (int i = 0; i < NE; i++) m_acc[i] = 0;
                m_draining = 1;
                m_idx = 0;
                m_active = !m_active;
                ack_count++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (dr_mode)
            0:       drain_ready = 1'b0;
            1:       drain_ready = 1'b1;
            default: drain_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        acc_valid = '0;
        swap_req = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("ready_first_cycle", acc_ready, 0);
        tick();
        @(negedge clk);
        chk("ready_after_release", acc_ready, 1);
        tick();
    endtask

    task automatic send_beat(input logic [1:0] vld, input logic [5:0] a0, input logic [7:0] d0,
                             input logic [5:0] a1, input logic [7:0] d1, input logic [1:0] bw);
        bit ok;
        ok = 0;
        acc_valid = vld;
        acc_addr  = {a1, a0};
        acc_data  = {d1, d0};
        bitwidth  = bw;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (acc_ready) begin ok = 1; break; end
        end
        if (!ok) chk("beat_accept_timeout", acc_ready, 1);
        tick();
    endtask

    task automatic do_swap();
        int base;
        base = ack_count;
        swap_req = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (ack_count != base) break;
        end
        swap_req = 1'b0;
        if (ack_count == base) chk("swap_ack_timeout", ack_count, base + 1);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 5000; c++) begin
            if (!m_draining) break;
            tick();
        end
        if (m_draining) chk("drain_timeout", m_idx, NE);
    endtask

    function automatic int count_nonzero();
        int n;
        n = 0;
        for (int i = 0; i < NE; i++) if (got_tile[i] != 16'h0) n++;
        return n;
    endfunction

    initial begin
        int tiles0, base, sbase;
        #1;
        do_reset();

        // Empty tile drains as 64 zeros in order.
        dr_mode = 1;
        do_swap();
        wait_drain();
        chk("t1_tiles", drained_tiles, 1);
        chk("t1_nonzero", count_nonzero(), 0);

        // 2-bit lane: 2'b11 is -1, three times.
        for (int i = 0; i < 3; i++) send_beat(2'b01, 6'd5, 8'h03, 6'd0, 8'h00, 2'd0);
        acc_valid = '0;
        do_swap();
        wait_drain();
        chk("t2_entry5", got_tile[5], 16'hFFFD);

        // Two lanes on one entry, back to back.
        for (int i = 0; i < 10; i++) send_beat(2'b11, 6'd7, 8'h7F, 6'd7, 8'h7F, 2'd2);
        acc_valid = '0;
        do_swap();
        wait_drain();
        chk("t3_entry7", got_tile[7], 16'd2540);
        chk("t3_overflow", overflow, 0);

        // Saturation at +32767.
        for (int i = 0; i < 130; i++) send_beat(2'b11, 6'd9, 8'h7F, 6'd9, 8'h7F, 2'd3);
        acc_valid = '0;
        do_swap();
        wait_drain();
        chk("t4_entry9", got_tile[9], 16'h7FFF);
        chk("t4_overflow", overflow, 1);

        // Swap request while the drain is stalled must wait for the whole tile.
        for (int i = 0; i < 4; i++) send_beat(2'b11, 6'(i), 8'h05, 6'(i + 32), 8'hF0, 2'd3);
        acc_valid = '0;
        dr_mode = 0;
        tiles0 = drained_tiles;
        do_swap();
        base = ack_count;
        swap_req = 1'b1;
        repeat (20) tick();
        chk("t5_no_early_ack", ack_count, base);
        dr_mode = 1;
        for (int c = 0; c < 500; c++) begin
            tick();
            if (ack_count != base) break;
        end
        swap_req = 1'b0;
        chk("t5_ack_seen", ack_count, base + 1);
        chk("t5_tile_done_before_ack", drained_tiles, tiles0 + 1);
        wait_drain();

        // Random traffic with random backpressure and interleaved swaps.
        dr_mode = 2;
        sbase = ack_count;
        for (int c = 0; c < 2500; c++) begin
            if (swap_req && ack_count != sbase) swap_req = 1'b0;
            else if (!swap_req && $urandom_range(0, 59) == 0) begin
                swap_req = 1'b1;
                sbase = ack_count;
            end
            acc_valid = 2'($urandom_range(0, 3));
            for (int l = 0; l < NL; l++) begin
                acc_addr[l*AW +: AW] = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 3))
                                                                   : 6'($urandom_range(0, 63));
                acc_data[l*IW +: IW] = 8'($urandom_range(0, 255));
            end
            bitwidth = 2'($urandom_range(0, 3));
            tick();
        end
        acc_valid = '0;
        if (swap_req) begin
            for (int c = 0; c < 3000; c++) begin
                if (ack_count != sbase) break;
                tick();
            end
            swap_req = 1'b0;
            tick();
        end
        dr_mode = 1;
        wait_drain();
        do_swap();
        wait_drain();

        // Reset in the middle of a drain discards the tile.
        for (int i = 0; i < 8; i++) send_beat(2'b11, 6'(i), 8'h11, 6'(i + 16), 8'h22, 2'd3);
        acc_valid = '0;
        do_swap();
        for (int c = 0; c < 500; c++) begin
            if (drain_valid && drain_addr == 6'd10) break;
            tick();
        end
        chk("t6_reached_addr10", drain_addr, 10);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_drain_valid", drain_valid, 0);
        tick();
        do_reset();
        do_swap();
        wait_drain();
        chk("t6_nonzero", count_nonzero(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
